// File: rtl/cdb_pkg.sv
// cdb_pkg: shared types and constants for the common-data-bus arbiter.
//   cdb_src_t    - identifies one of the four functional-unit result queues
//   NUM_CDB_SRC  - number of queues competing for the CDB
//   CDB_TAG_W    - default producer tag width
//   CDB_DATA_W   - default result width
//   next_src()   - round-robin successor, wrapping DIV back to ALU
package cdb_pkg;

  typedef enum logic [1:0] {
    ALU = 2'd0,
    AGU = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } cdb_src_t;

  localparam int NUM_CDB_SRC = 4;
  localparam int CDB_TAG_W   = 5;
  localparam int CDB_DATA_W  = 32;

  // Two-bit increment wraps naturally, so DIV + 1 lands on ALU.
  function automatic cdb_src_t next_src(input cdb_src_t src);
    logic [1:0] nxt;
    nxt = src + 2'd1;
    return cdb_src_t'(nxt);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: request/grant handshake from the four result queues and the
// registered CDB broadcast toward the reservation stations, register status
// table and store queue.
//   req        - per-queue result-ready, [0]=ALU [1]=AGU [2]=MUL [3]=DIV
//   tag_in     - per-queue producer tag, packed by queue index
//   data_in    - per-queue result, packed by queue index
//   gnt        - one-hot grant, combinational in the request cycle
//   cdb_valid  - broadcast valid
//   cdb_tag    - broadcast tag
//   cdb_data   - broadcast result
//   mux_sel    - source of the current broadcast (CDB mux select)
// Modports: master = arbiter side (drives grant and the bus),
//           slave  = queue/consumer side.
interface cdb_arbiter_if #(
  parameter int TAG_W  = cdb_pkg::CDB_TAG_W,
  parameter int DATA_W = cdb_pkg::CDB_DATA_W
);
  import cdb_pkg::*;

  logic [NUM_CDB_SRC-1:0]        req;
  logic [NUM_CDB_SRC*TAG_W-1:0]  tag_in;
  logic [NUM_CDB_SRC*DATA_W-1:0] data_in;
  logic [NUM_CDB_SRC-1:0]        gnt;
  logic                          cdb_valid;
  logic [TAG_W-1:0]              cdb_tag;
  logic [DATA_W-1:0]             cdb_data;
  cdb_src_t                      mux_sel;

  modport master (
    input  req,
    input  tag_in,
    input  data_in,
    output gnt,
    output cdb_valid,
    output cdb_tag,
    output cdb_data,
    output mux_sel
  );

  modport slave (
    output req,
    output tag_in,
    output data_in,
    input  gnt,
    input  cdb_valid,
    input  cdb_tag,
    input  cdb_data,
    input  mux_sel
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick4.sv
// rr_pick4: combinational four-way round-robin pick.
//   req  - request vector
//   ptr  - highest-priority queue this cycle
//   gnt  - one-hot winner (zero when req is zero)
//   idx  - encoded winner; only meaningful when gnt is non-zero
// Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first requester wins.
module rr_pick4
  import cdb_pkg::*;
(
  input  logic [NUM_CDB_SRC-1:0] req,
  input  cdb_src_t               ptr,
  output logic [NUM_CDB_SRC-1:0] gnt,
  output cdb_src_t               idx
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    gnt   = '0;
    idx   = ALU;
    cand  = 2'd0;
    found = 1'b0;
    for (int i = 0; i < NUM_CDB_SRC; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cdb_src_t'(cand);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants the common data bus to one of the ALU/AGU/MUL/DIV result
// queues per cycle with round-robin fairness and registers the winner's tag
// and result as the CDB broadcast.
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   flush  - pipeline flush; suppresses this cycle's grant and broadcast
//   bus    - cdb_arbiter_if.master: req/tag_in/data_in in, gnt and
//            cdb_valid/cdb_tag/cdb_data/mux_sel out
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.master bus
);

  cdb_src_t               ptr;
  cdb_src_t               ptr_next;
  logic [NUM_CDB_SRC-1:0] pick_gnt;
  cdb_src_t               pick_idx;
  logic [NUM_CDB_SRC-1:0] gnt_q;
  logic                   grant_any;

  logic [TAG_W-1:0]       tag_arr  [NUM_CDB_SRC];
  logic [DATA_W-1:0]      data_arr [NUM_CDB_SRC];

  logic                   cdb_valid_r;
  logic [TAG_W-1:0]       cdb_tag_r;
  logic [DATA_W-1:0]      cdb_data_r;
  cdb_src_t               mux_sel_r;

  for (genvar g = 0; g < NUM_CDB_SRC; g++) begin : g_unpack
    assign tag_arr[g]  = bus.tag_in[g*TAG_W +: TAG_W];
    assign data_arr[g] = bus.data_in[g*DATA_W +: DATA_W];
  end

  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Reset and flush both kill the grant in the same cycle, so a requester
  // never sees a gnt for a result that will not be broadcast.
  always_comb begin
    gnt_q     = '0;
    grant_any = 1'b0;
    ptr_next  = ptr;
    if (!rst && !flush) begin
      gnt_q     = pick_gnt;
      grant_any = |pick_gnt;
    end
    if (grant_any) begin
      ptr_next = next_src(pick_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= ALU;
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= '0;
      cdb_data_r  <= '0;
      mux_sel_r   <= ALU;
    end else begin
      ptr         <= ptr_next;
      cdb_valid_r <= grant_any;
      // Tag/data/source hold their last broadcast values when idle.
      if (grant_any) begin
        cdb_tag_r  <= tag_arr[pick_idx];
        cdb_data_r <= data_arr[pick_idx];
        mux_sel_r  <= pick_idx;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.cdb_valid = cdb_valid_r;
  assign bus.cdb_tag   = cdb_tag_r;
  assign bus.cdb_data  = cdb_data_r;
  assign bus.mux_sel   = mux_sel_r;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the common data bus (CDB) of the Tomasulo back end between the four functional-unit result queues: ALU, AGU, MUL and DIV. Each cycle the block grants at most one queue with round-robin fairness, registers the winner's tag and result, and broadcasts them to the reservation stations, register status table and store queue. It sits at the output of the issue/execute stage, and its source-select output is the `mux_sel` that drives the CDB multiplexer.

## Interface
Parameters:
- `TAG_W`, default 5: width of the producer tag broadcast on the CDB.
- `DATA_W`, default 32: result width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  pipeline flush; cancels arbitration and the pending broadcast.
- `req`  in  4  per-queue result-ready request. Bit order: [0]=ALU, [1]=AGU, [2]=MUL, [3]=DIV.
- `tag_in`  in  4×TAG_W  per-queue producer tag, packed by queue index.
- `data_in`  in  4×DATA_W  per-queue result, packed by queue index.
- `gnt`  out  4  one-hot grant, combinational in the request cycle.
- `mux_sel`  out  2  registered source of the current broadcast, of type `cdb_src_t`.
- `cdb_valid`  out  1  broadcast valid.
- `cdb_tag`  out  TAG_W  broadcast tag.
- `cdb_data`  out  DATA_W  broadcast result.

## Operation
- Arbitration uses round-robin with priority pointer `ptr` (2 bits). The search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4. The first queue in that order with `req` set wins.
- On a grant to queue k, `ptr` becomes k+1 mod 4 on the next edge, so the index wraps from DIV back to ALU. With no grant, `ptr` holds.
- Handshake: a requester holds `req`, `tag_in` and `data_in` stable until it sees `gnt` in the same cycle. It may drop `req` or present the next entry in the following cycle. A requester must not retract `req` without a grant.
- `gnt` is at most one-hot. It is zero when `req`==0, `flush`==1 or `rst`==1.
- Output stage: on the grant edge, register `cdb_valid`=1, `cdb_tag`=tag_in[k], `cdb_data`=data_in[k] and `mux_sel`=k. With no grant, `cdb_valid`=0 and tag/data/mux_sel hold their last values.
- Flush: `gnt`=0 that cycle, `cdb_valid`=0 on the next edge, and `ptr` is unchanged. A broadcast already valid in the flush cycle still completes in that cycle.
- Fairness: a continuously asserted request is granted within 4 cycles, including its own cycle.
- There is no internal buffering, and the CDB is never back-pressured. One result retires per cycle.

## Timing
- Reset values: `ptr`=ALU(0), `cdb_valid`=0, `cdb_tag`=0, `cdb_data`=0, `mux_sel`=ALU. `gnt`=0 while `rst` is high.
- Latency: `req` sampled in cycle N gives `gnt` in cycle N and `cdb_*` valid in cycle N+1 for exactly one cycle.
- Throughput: one broadcast per cycle, sustained.
- Back-to-back grants from the same queue are allowed only when no other queue requests.
- Reset or flush mid-stream: no grant is issued in that cycle, and nothing partial is broadcast.
- Reset takes priority over flush.

## Structure
- `cdb_pkg` holds:
  - `typedef enum logic [1:0] {ALU=0, AGU=1, MUL=2, DIV=3} cdb_src_t`.
  - `localparam NUM_CDB_SRC=4`.
  - The default `TAG_W` and `DATA_W`.
- One natural sub-module is `rr_pick4`: purely combinational, taking `req` and `ptr` and returning one-hot `gnt` plus a 2-bit index. Packing and register logic stay in `cdb_arbiter`.

## Test plan
- Reset, then a single request: `req`=4'b0100 with tag 5'd7 and data 32'h1234 in cycle 1. Expect `gnt`=4'b0100 in cycle 1; in cycle 2, `cdb_valid`=1, `cdb_tag`=7, `cdb_data`=32'h1234, `mux_sel`=MUL; in cycle 3, `cdb_valid`=0.
- All four queues request continuously from reset. Expect the grant order ALU, AGU, MUL, DIV, ALU with no idle cycle, `cdb_valid` high every cycle from cycle 2, and `mux_sel` sequence 0,1,2,3,0.
- Starvation bound: ALU requests every cycle, and DIV asserts `req` with `ptr`=AGU. Expect DIV granted within 3 cycles and ALU granted the cycle after.
- Wrap-around: last grant was DIV, then `req`=4'b1001. Expect ALU granted first and DIV in the next cycle.
- Flush: `req`=4'b0011 with `flush`=1 in cycle N. Expect `gnt`=0, `cdb_valid`=0 at N+1 and `ptr` unchanged. In cycle N+1 with `flush`=0, the grant goes to the same queue that would have won in cycle N.
- Reset asserted while all requests are active. Expect `gnt`=0, then on the next edge all outputs at their reset values and `ptr`=ALU. The first grant after reset is ALU.
